// File: rtl/onewire_bit_engine_if.sv
// Handshake and bus signals of the 1-wire bit engine.
// master = byte source / host / bus side, slave = the engine.
interface onewire_bit_engine_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ack;
  logic       cmd_reset;
  logic       rd_req;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       presence;
  logic       busy;
  logic       bus_pull_low;
  logic       bus_in;

  modport master (
    output tx_valid, tx_data, cmd_reset, rd_req, bus_in,
    input  tx_ack, rx_byte, rx_valid, presence, busy, bus_pull_low
  );

  modport slave (
    input  tx_valid, tx_data, cmd_reset, rd_req, bus_in,
    output tx_ack, rx_byte, rx_valid, presence, busy, bus_pull_low
  );
endinterface

// File: rtl/onewire_bit_engine.sv
// 1-wire bit engine: serialises FIFO bytes as write slots, runs reset/presence
// sequences and 8-slot byte reads. Open-drain: only pulls low or releases.
//
// state    | meaning
// IDLE     | bus released, waiting for cmd_reset / tx_valid / rd_req
// RST_LOW  | reset pulse, bus low 480 us
// RST_WAIT | released 70 us, presence sampled at the end
// RST_REC  | released 410 us recovery
// W_LOW    | write slot low part, 6 us for a 1, 60 us for a 0
// W_REL    | write slot release, remainder of the 70 us slot
// R_LOW    | read slot low 6 us
// R_SAMP   | read slot release 9 us, bus sampled at the end
// R_REC    | read slot recovery 55 us
module onewire_bit_engine #(
  parameter int CLK_PER_US = 4,
  parameter int US_W       = 10
) (
  input logic               clock,
  input logic               reset,
  onewire_bit_engine_if.slave bus
);
  localparam int PRE_W = $clog2(CLK_PER_US);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_PER_US - 1);

  localparam logic [US_W-1:0] T_RST_LOW  = US_W'(480);
  localparam logic [US_W-1:0] T_RST_WAIT = US_W'(70);
  localparam logic [US_W-1:0] T_RST_REC  = US_W'(410);
  localparam logic [US_W-1:0] T_W1_LOW   = US_W'(6);
  localparam logic [US_W-1:0] T_W0_LOW   = US_W'(60);
  localparam logic [US_W-1:0] T_W1_REL   = US_W'(64);
  localparam logic [US_W-1:0] T_W0_REL   = US_W'(10);
  localparam logic [US_W-1:0] T_R_LOW    = US_W'(6);
  localparam logic [US_W-1:0] T_R_SAMP   = US_W'(9);
  localparam logic [US_W-1:0] T_R_REC    = US_W'(55);

  typedef enum logic [3:0] {
    IDLE, RST_LOW, RST_WAIT, RST_REC, W_LOW, W_REL, R_LOW, R_SAMP, R_REC
  } state_t;

  state_t           state;
  logic [PRE_W-1:0] pre_cnt;
  logic [US_W-1:0]  us_cnt;
  logic [US_W-1:0]  phase_us;
  logic [2:0]       bit_cnt;
  logic [7:0]       tx_sh;
  logic [7:0]       rx_sh;
  logic             phase_end;

  always_comb begin
    phase_us = US_W'(1);
    unique case (state)
      RST_LOW:  phase_us = T_RST_LOW;
      RST_WAIT: phase_us = T_RST_WAIT;
      RST_REC:  phase_us = T_RST_REC;
      W_LOW:    phase_us = tx_sh[0] ? T_W1_LOW : T_W0_LOW;
      W_REL:    phase_us = tx_sh[0] ? T_W1_REL : T_W0_REL;
      R_LOW:    phase_us = T_R_LOW;
      R_SAMP:   phase_us = T_R_SAMP;
      R_REC:    phase_us = T_R_REC;
      default:  phase_us = US_W'(1);
    endcase
  end

  assign phase_end = (state != IDLE) && (pre_cnt == PRE_LAST) &&
                     (us_cnt == phase_us - US_W'(1));

  always_ff @(posedge clock) begin
    if (!reset) begin
      state            <= IDLE;
      pre_cnt          <= '0;
      us_cnt           <= '0;
      bit_cnt          <= '0;
      tx_sh            <= '0;
      rx_sh            <= '0;
      bus.tx_ack       <= 1'b0;
      bus.rx_byte      <= '0;
      bus.rx_valid     <= 1'b0;
      bus.presence     <= 1'b0;
      bus.busy         <= 1'b0;
      bus.bus_pull_low <= 1'b0;
    end else begin
      bus.tx_ack   <= 1'b0;
      bus.rx_valid <= 1'b0;

      // every state change happens on phase_end, so clearing here restarts the timebase on entry
      if (state == IDLE || phase_end) begin
        pre_cnt <= '0;
        us_cnt  <= '0;
      end else if (pre_cnt == PRE_LAST) begin
        pre_cnt <= '0;
        us_cnt  <= us_cnt + US_W'(1);
      end else begin
        pre_cnt <= pre_cnt + PRE_W'(1);
      end

      unique case (state)
        IDLE: begin
          if (bus.cmd_reset) begin
            state            <= RST_LOW;
            bus.busy         <= 1'b1;
            bus.bus_pull_low <= 1'b1;
          end else if (bus.tx_valid) begin
            state            <= W_LOW;
            tx_sh            <= bus.tx_data;
            bit_cnt          <= '0;
            bus.tx_ack       <= 1'b1;
            bus.busy         <= 1'b1;
            bus.bus_pull_low <= 1'b1;
          end else if (bus.rd_req) begin
            state            <= R_LOW;
            rx_sh            <= '0;
            bit_cnt          <= '0;
            bus.busy         <= 1'b1;
            bus.bus_pull_low <= 1'b1;
          end
        end
        RST_LOW: if (phase_end) begin
          state            <= RST_WAIT;
          bus.bus_pull_low <= 1'b0;
        end
        RST_WAIT: if (phase_end) begin
          state        <= RST_REC;
          bus.presence <= ~bus.bus_in;
        end
        RST_REC: if (phase_end) begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        W_LOW: if (phase_end) begin
          state            <= W_REL;
          bus.bus_pull_low <= 1'b0;
        end
        W_REL: if (phase_end) begin
          if (bit_cnt == 3'd7) begin
            // back-to-back streaming: next byte starts without an IDLE cycle
            if (bus.tx_valid && !bus.cmd_reset) begin
              state            <= W_LOW;
              tx_sh            <= bus.tx_data;
              bit_cnt          <= '0;
              bus.tx_ack       <= 1'b1;
              bus.bus_pull_low <= 1'b1;
            end else begin
              state    <= IDLE;
              bit_cnt  <= '0;
              bus.busy <= 1'b0;
            end
          end else begin
            state            <= W_LOW;
            tx_sh            <= tx_sh >> 1;
            bit_cnt          <= bit_cnt + 3'd1;
            bus.bus_pull_low <= 1'b1;
          end
        end
        R_LOW: if (phase_end) begin
          state            <= R_SAMP;
          bus.bus_pull_low <= 1'b0;
        end
        R_SAMP: if (phase_end) begin
          state          <= R_REC;
          rx_sh[bit_cnt] <= bus.bus_in;
        end
        R_REC: if (phase_end) begin
          if (bit_cnt == 3'd7) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            bus.rx_byte  <= rx_sh;
            bus.rx_valid <= 1'b1;
            bus.busy     <= 1'b0;
          end else begin
            state            <= R_LOW;
            bit_cnt          <= bit_cnt + 3'd1;
            bus.bus_pull_low <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
